// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: D = A - B - Bin, one decimal digit per
// clock, least-significant digit first, with a start/busy/done handshake.
module bcd_serial_subtractor #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] A,
    input  logic [4*DIGITS-1:0] B,
    input  logic                Bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] D,
    output logic                Bout,
    output logic                invalid
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             br_q, br_d;
    logic [W-1:0]     d_q, d_d;
    logic             bout_q, bout_d;
    logic             inv_q, inv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [3:0]       a_dig;
    logic [3:0]       b_dig;
    logic [4:0]       dig_res;

    // One decimal digit of a - b - br; returns {borrow_out, digit}.
    // Out-of-range digits go through the same formula, keeping the low 4 bits.
    function automatic logic [4:0] sub_digit(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic       br_in);
        logic signed [5:0] t;
        t = $signed({2'b00, a}) - $signed({2'b00, b}) - $signed({5'b00000, br_in});
        if (t < 0) begin
            t = t + 6'sd10;
            return {1'b1, t[3:0]};
        end
        return {1'b0, t[3:0]};
    endfunction

    assign a_dig   = a_q[{idx_q, 2'b00} +: 4];
    assign b_dig   = b_q[{idx_q, 2'b00} +: 4];
    assign dig_res = sub_digit(a_dig, b_dig, br_q);

    // Next-state logic: accept a request when idle/done, then walk the digits.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        d_d     = d_q;
        bout_d  = bout_q;
        inv_d   = inv_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    d_d     = '0;
                    bout_d  = 1'b0;
                    inv_d   = 1'b0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                d_d[{idx_q, 2'b00} +: 4] = dig_res[3:0];
                br_d  = dig_res[4];
                inv_d = inv_q | (a_dig > 4'd9) | (b_dig > 4'd9);
                if (idx_q == LAST_IDX) begin
                    bout_d  = dig_res[4];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            br_q    <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            br_q    <= br_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            inv_q   <= inv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Latched operands are pure data and only change on an accepted start.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign D       = d_q;
    assign Bout    = bout_q;
    assign invalid = inv_q;

endmodule
